i2c_bert_controller: RTL and testbench
======================================

# i2c_bert_controller

Single-byte I2C controller (initiator) for the I2C BERT design: the opposite end of the bus from the BERT target. It accepts one command at a time over a valid/ready handshake and runs START, 7-bit address + R/W, ACK, one data byte, ACK/NACK, STOP on open-drain SCL/SDA. It sits on-chip or in the bench as the bus driver that exercises the target. It reports the read byte and any NACK through a single-cycle response pulse.

## Interface
Parameters:
- CLKDIV, 4: clk cycles per SCL quarter-period; legal range 2..255.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller idle; command accepted when cmd_valid & cmd_ready.
- cmd_addr  in  7  target address.
- cmd_rnw  in  1  1 = read, 0 = write.
- cmd_data  in  8  write byte; ignored on read.
- rsp_valid  out  1  one-cycle pulse at transaction end.
- rsp_data  out  8  byte read; 8'h00 after a write or address NACK.
- rsp_nack  out  1  1 = address or write-data NACK seen; valid with rsp_valid.
- scl_oe  out  1  1 = pull SCL low, 0 = release.
- sda_oe  out  1  1 = pull SDA low, 0 = release.
- scl_in  in  1  bus SCL level, for clock stretching.
- sda_in  in  1  bus SDA level, for ACK and read data.

## Operation
- Reset values: cmd_ready=1, scl_oe=0, sda_oe=0, rsp_valid=0, rsp_data=8'h00, rsp_nack=0. State is IDLE.
- On accept, latch addr, rnw and data, then drop cmd_ready. Command inputs are don't-care until the next accept.
- Bit framing uses 4 quarters per bit:
  - Q0: SCL low; SDA changes to the next bit.
  - Q1: SCL low.
  - Q2: SCL released.
  - Q3: SCL high; SDA is sampled on the first cycle of Q3.
- Clock stretching: Q2 does not end while scl_in=0. The quarter counter holds until scl_in=1, then Q2 runs for its full CLKDIV cycles.
- States:
  - IDLE: wait for accept.
  - START: SDA falls while SCL is high, then SCL goes low.
  - ADDR: 8 bits, address MSB-first, then rnw.
  - AACK: release SDA and sample it. A 1 (NACK) sets rsp_nack and moves to STOP.
  - DATA, write: drive cmd_data MSB-first.
  - DATA, read: release SDA and shift in sda_in MSB-first.
  - DACK, write: sample ACK; a 1 sets rsp_nack.
  - DACK, read: controller drives NACK (SDA released), as the last-byte rule requires.
  - STOP: SDA low with SCL low, release SCL, then release SDA.
  - DONE: pulse rsp_valid, go to IDLE.
- Open drain only: a 1 bit is sent as sda_oe=0. The bus is never driven high.
- sda_in is ignored except at sample points. There is no arbitration or multi-controller support.
- Reset mid-transaction: both lines are released immediately and no response is issued. The bus may see a truncated frame; the target is expected to recover on the next START.

## Timing
- Tick: one quarter equals CLKDIV clk cycles, absent stretching.
- Length without stretching: START 4 + ADDR 32 + AACK 4 + DATA 32 + DACK 4 + STOP 4 = 80 quarters, i.e. 80·CLKDIV cycles from the cycle after accept to STOP complete.
- Length with address NACK: 44 quarters.
- Stretching adds exactly the cycles during which scl_in=0 in Q2.
- rsp_valid is high for exactly one cycle, on the cycle after the last STOP quarter.
- cmd_ready returns to 1 on that same cycle. A back-to-back command may be accepted on that cycle, and its START begins on the next cycle.
- rsp_data and rsp_nack hold their values until the next rsp_valid.
- SDA changes only while SCL is low, except the START/STOP edges. Each SCL-high phase is at least 2·CLKDIV cycles, since Q2 and Q3 are both high.

## Structure
- Shared package i2c_bert_pkg holds:
  - state enum (IDLE, START, ADDR, AACK, DATA, DACK, STOP, DONE);
  - quarter-phase constants Q0..Q3;
  - I2C_ACK=1'b0 and I2C_NACK=1'b1.
- Sub-module i2c_bert_qtick: CLKDIV down-counter with a stretch-hold input. It outputs the quarter-end strobe and the 2-bit phase.
- The top level holds the FSM, the 3-bit bit counter and the 8-bit shift register.

## Test plan
- Write, CLKDIV=4, addr 7'h5A, data 8'hC3, target ACKs both bytes. Bus must show address byte 8'hB4 then 8'hC3. Expect rsp_nack=0 and rsp_valid exactly 320 cycles after accept.
- Read, addr 7'h5A, target returns 8'h96. Address byte on the bus must be 8'hB5. Expect rsp_data=8'h96 and the controller's 9th bit released as NACK.
- Address NACK (sda_in held 1), addr 7'h11. Expect STOP right after AACK, rsp_nack=1, rsp_data=8'h00, response at 176 cycles.
- Stretch: hold scl_in low for 37 cycles during the ADDR bit-3 Q2. Expect the response 37 cycles later than unstretched, with correct data.
- Back-to-back: cmd_valid held high with two commands. The second must be accepted on the rsp_valid cycle of the first, and its START must begin the next cycle.
- Async rst asserted mid-DATA. Expect scl_oe=sda_oe=0 and cmd_ready=1 in the same cycle, no rsp_valid, and a following command that completes normally.

Source files
------------

// File: rtl/i2c_bert_pkg.sv
// ---------------------------------------------------------------------------
// i2c_bert_pkg
// Shared definitions for the I2C BERT controller:
//   - state_t      : controller FSM states
//   - Q0..Q3       : quarter-phase encodings of one I2C bit slot
//   - I2C_ACK/NACK : SDA levels of the acknowledge bit
//   - bus_drive()  : open-drain drive pattern {scl_oe, sda_oe} for a given
//                    state, quarter phase and transmit bit
// ---------------------------------------------------------------------------
package i2c_bert_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ADDR  = 3'd2,
        AACK  = 3'd3,
        DATA  = 3'd4,
        DACK  = 3'd5,
        STOP  = 3'd6,
        DONE  = 3'd7
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    // Returns {scl_oe, sda_oe}; a 1 pulls the line low, a 0 releases it.
    // SCL is released in Q2 of every state so that stretching can never
    // deadlock against our own pull-down.
    function automatic logic [1:0] bus_drive(input state_t  st,
                                             input logic [1:0] ph,
                                             input logic    tx_bit,
                                             input logic    rd);
        logic       low_half;
        logic [1:0] drv;
        low_half = (ph == Q0) || (ph == Q1);
        drv      = 2'b00;
        case (st)
            // SDA falls in Q1 while SCL is high, SCL follows in Q3.
            START:      drv = {(ph == Q3), (ph != Q0)};
            ADDR:       drv = {low_half, ~tx_bit};
            // On a read the target owns SDA during the data byte.
            DATA:       drv = {low_half, (rd ? 1'b0 : ~tx_bit)};
            // Write DACK: let the target answer; read DACK: our NACK.
            AACK, DACK: drv = {low_half, 1'b0};
            // SDA low through Q2, SCL rises in Q2, SDA rises in Q3.
            STOP:       drv = {low_half, (ph != Q3)};
            default:    drv = 2'b00;
        endcase
        return drv;
    endfunction

endpackage

// File: rtl/i2c_bert_qtick.sv
// ---------------------------------------------------------------------------
// i2c_bert_qtick
// Quarter-period timebase. A down-counter of CLKDIV clk cycles per quarter
// and a 2-bit phase that advances Q0->Q1->Q2->Q3->Q0 at each quarter end.
// While SCL is held low by another device during Q2 the counter is held at
// its reload value, so Q2 runs its full length once SCL is seen high.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   run      : 1 while a frame is in progress; 0 parks the timebase at Q0
//   scl_in   : bus SCL level (assumed synchronous to clk)
//   qend     : strobe on the last cycle of a quarter
//   first    : 1 on the first cycle of a quarter
//   phase    : current quarter phase
// ---------------------------------------------------------------------------
module i2c_bert_qtick
    import i2c_bert_pkg::*;
#(
    parameter int CLKDIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       scl_in,
    output logic       qend,
    output logic       first,
    output logic [1:0] phase
);

    localparam logic [7:0] RELOAD = 8'(CLKDIV - 1);

    logic [7:0] cnt_r;
    logic [1:0] phase_r;
    logic       hold_s;
    logic       qend_s;

    // Stretch detection and quarter-end strobe.
    always_comb begin
        hold_s = 1'b0;
        qend_s = 1'b0;
        if (run && (phase_r == Q2) && !scl_in) begin
            hold_s = 1'b1;
        end else begin
            hold_s = 1'b0;
        end
        if (run && !hold_s && (cnt_r == 8'd0)) begin
            qend_s = 1'b1;
        end else begin
            qend_s = 1'b0;
        end
    end

    // Quarter counter and phase register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= RELOAD;
            phase_r <= Q0;
        end else if (!run) begin
            cnt_r   <= RELOAD;
            phase_r <= Q0;
        end else if (hold_s) begin
            cnt_r   <= RELOAD;
        end else if (cnt_r == 8'd0) begin
            cnt_r   <= RELOAD;
            phase_r <= phase_r + 2'd1;
        end else begin
            cnt_r   <= cnt_r - 8'd1;
        end
    end

    assign qend  = qend_s;
    assign first = (cnt_r == RELOAD);
    assign phase = phase_r;

endmodule

// File: rtl/i2c_bert_controller.sv
// ---------------------------------------------------------------------------
// i2c_bert_controller
// Single-byte I2C initiator. Accepts one command (addr, rnw, data) over a
// valid/ready handshake, runs START, address+R/W, ACK, one data byte,
// ACK/NACK, STOP on open-drain SCL/SDA and reports the outcome with a
// one-cycle rsp_valid pulse.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (ready = controller idle)
//   cmd_addr/rnw/data   : 7-bit target address, 1 = read, write byte
//   rsp_valid           : one-cycle pulse at transaction end
//   rsp_data            : byte read (8'h00 after a write or address NACK)
//   rsp_nack            : address or write-data NACK seen
//   scl_oe/sda_oe       : 1 pulls the line low, 0 releases it
//   scl_in/sda_in       : bus levels for stretching, ACK and read data
// All bus drive and response outputs are registered; their next values are
// decoded from the FSM's next state so the lines change in step with it.
// ---------------------------------------------------------------------------
module i2c_bert_controller
    import i2c_bert_pkg::*;
#(
    parameter int CLKDIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rnw,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_nack,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_in,
    input  logic       sda_in
);

    state_t     state_r;
    state_t     state_nx_s;
    logic [2:0] bit_r;
    logic [2:0] bit_nx_s;
    logic [7:0] sh_r;
    logic [7:0] sh_nx_s;
    logic [7:0] data_r;
    logic       rnw_r;
    logic       nack_r;
    logic       nack_nx_s;
    logic       samp_r;
    logic       samp_nx_s;

    logic       cmd_ready_r;
    logic       rsp_valid_r;
    logic [7:0] rsp_data_r;
    logic       rsp_nack_r;
    logic       scl_oe_r;
    logic       sda_oe_r;

    logic       run_s;
    logic       qend_s;
    logic       first_s;
    logic [1:0] phase_s;
    logic [1:0] phase_nx_s;
    logic       accept_s;
    logic       bit_end_s;
    logic       sample_s;
    logic [1:0] drive_s;

    // The timebase only runs while a frame is on the bus.
    always_comb begin
        run_s = 1'b0;
        case (state_r)
            START, ADDR, AACK, DATA, DACK, STOP: run_s = 1'b1;
            default:                             run_s = 1'b0;
        endcase
    end

    i2c_bert_qtick #(
        .CLKDIV (CLKDIV)
    ) u_qtick (
        .clk    (clk),
        .rst    (rst),
        .run    (run_s),
        .scl_in (scl_in),
        .qend   (qend_s),
        .first  (first_s),
        .phase  (phase_s)
    );

    // Handshake, bit-slot boundaries and the predicted next phase.
    always_comb begin
        accept_s   = cmd_valid & cmd_ready_r;
        bit_end_s  = qend_s & (phase_s == Q3);
        // SDA is sampled once, on the first cycle of the SCL-high Q3.
        sample_s   = run_s & first_s & (phase_s == Q3);
        if (qend_s) begin
            phase_nx_s = phase_s + 2'd1;
        end else begin
            phase_nx_s = phase_s;
        end
    end

    // FSM next state with bit counter, shift register and ACK capture.
    always_comb begin
        state_nx_s = state_r;
        bit_nx_s   = bit_r;
        sh_nx_s    = sh_r;
        nack_nx_s  = nack_r;
        samp_nx_s  = samp_r;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    state_nx_s = START;
                    sh_nx_s    = {cmd_addr, cmd_rnw};
                    bit_nx_s   = 3'd7;
                    nack_nx_s  = 1'b0;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_nx_s = ADDR;
                end else begin
                    state_nx_s = START;
                end
            end
            ADDR: begin
                if (bit_end_s) begin
                    if (bit_r == 3'd0) begin
                        state_nx_s = AACK;
                    end else begin
                        bit_nx_s = bit_r - 3'd1;
                        sh_nx_s  = {sh_r[6:0], 1'b0};
                    end
                end else begin
                    state_nx_s = ADDR;
                end
            end
            AACK: begin
                if (sample_s) begin
                    samp_nx_s = sda_in;
                end else begin
                    samp_nx_s = samp_r;
                end
                if (bit_end_s) begin
                    if (samp_r == I2C_NACK) begin
                        nack_nx_s  = 1'b1;
                        state_nx_s = STOP;
                    end else begin
                        state_nx_s = DATA;
                        bit_nx_s   = 3'd7;
                        // A read shifts in from zero; a write shifts out.
                        sh_nx_s    = rnw_r ? 8'h00 : data_r;
                    end
                end else begin
                    state_nx_s = AACK;
                end
            end
            DATA: begin
                if (rnw_r && sample_s) begin
                    sh_nx_s = {sh_r[6:0], sda_in};
                end else begin
                    sh_nx_s = sh_r;
                end
                if (bit_end_s) begin
                    if (bit_r == 3'd0) begin
                        state_nx_s = DACK;
                    end else begin
                        bit_nx_s = bit_r - 3'd1;
                        if (!rnw_r) begin
                            sh_nx_s = {sh_r[6:0], 1'b0};
                        end else begin
                            sh_nx_s = sh_r;
                        end
                    end
                end else begin
                    state_nx_s = DATA;
                end
            end
            DACK: begin
                if (sample_s) begin
                    samp_nx_s = sda_in;
                end else begin
                    samp_nx_s = samp_r;
                end
                if (bit_end_s) begin
                    state_nx_s = STOP;
                    // Only a write byte can be NACKed by the target.
                    if (!rnw_r && (samp_r == I2C_NACK)) begin
                        nack_nx_s = 1'b1;
                    end else begin
                        nack_nx_s = nack_r;
                    end
                end else begin
                    state_nx_s = DACK;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = STOP;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Bus drive pattern for the cycle that follows this edge.
    always_comb begin
        drive_s = bus_drive(state_nx_s, phase_nx_s, sh_nx_s[7], rnw_r);
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            bit_r   <= 3'd0;
            sh_r    <= 8'h00;
            nack_r  <= 1'b0;
            samp_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            bit_r   <= bit_nx_s;
            sh_r    <= sh_nx_s;
            nack_r  <= nack_nx_s;
            samp_r  <= samp_nx_s;
        end
    end

    // Command fields that must survive until the end of the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= 8'h00;
            rnw_r  <= 1'b0;
        end else if (accept_s) begin
            data_r <= cmd_data;
            rnw_r  <= cmd_rnw;
        end
    end

    // Registered bus drive; reset releases both lines at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_oe_r <= 1'b0;
            sda_oe_r <= 1'b0;
        end else begin
            scl_oe_r <= drive_s[1];
            sda_oe_r <= drive_s[0];
        end
    end

    // Handshake and response registers; response fields hold between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 8'h00;
            rsp_nack_r  <= 1'b0;
        end else begin
            cmd_ready_r <= (state_nx_s == IDLE) || (state_nx_s == DONE);
            rsp_valid_r <= (state_nx_s == DONE);
            if (state_nx_s == DONE) begin
                rsp_data_r <= (rnw_r && !nack_nx_s) ? sh_nx_s : 8'h00;
                rsp_nack_r <= nack_nx_s;
            end
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_nack  = rsp_nack_r;
    assign scl_oe    = scl_oe_r;
    assign sda_oe    = sda_oe_r;

endmodule

// File: tb/tb_i2c_bert_controller.sv
// ---------------------------------------------------------------------------
// tb_i2c_bert_controller
// Directed bench for i2c_bert_controller (CLKDIV = 4) with a wired-AND bus,
// a simple target model that ACKs and returns a read byte, a bus monitor
// that decodes address/data/ACK bits, and an SCL-stretch injector.
// ---------------------------------------------------------------------------
module tb_i2c_bert_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_addr = 7'h00;
    logic       cmd_rnw = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_nack;
    logic       scl_oe;
    logic       sda_oe;
    logic       scl_line;
    logic       sda_line;

    // target model / stretcher controls
    logic       tgt_en = 1'b1;
    logic [7:0] tgt_rd = 8'h00;
    logic       tgt_low = 1'b0;
    logic       stretch = 1'b0;
    logic       stretch_en = 1'b0;
    int         since_acc = 0;

    // monitor state
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    int         fall_cnt = 0;
    int         stop_fall = 0;
    int         rsp_count = 0;
    logic [7:0] mon_addr = 8'h00;
    logic [7:0] mon_data = 8'h00;
    logic       mon_aack = 1'b0;
    logic       mon_dack = 1'b0;

    int total = 0;
    int bad = 0;
    int lat;

    assign scl_line = ~scl_oe & ~stretch;
    assign sda_line = ~sda_oe & ~tgt_low;

    i2c_bert_controller #(.CLKDIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_rnw   (cmd_rnw),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_nack  (rsp_nack),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .scl_in    (scl_line),
        .sda_in    (sda_line)
    );

    always #5 clk = ~clk;

    // Target pull-down for bus bit slot n (1..8 addr, 9 AACK, 10..17 data, 18 DACK).
    function automatic logic tgt_next(input int n);
        logic rd;
        rd = mon_addr[0];
        if (!tgt_en) return 1'b0;
        if (n == 9) return 1'b1;
        if (n == 18) return !rd;
        if (n >= 10 && n <= 17 && rd) return !tgt_rd[17 - n];
        return 1'b0;
    endfunction

    // Bus monitor and target, sampled on the falling clk edge.
    always @(negedge clk) begin
        prev_scl <= scl_line;
        prev_sda <= sda_line;
        if (prev_scl && scl_line && prev_sda && !sda_line) begin
            fall_cnt <= 0;
            mon_addr <= 8'h00;
            mon_data <= 8'h00;
            tgt_low  <= 1'b0;
        end else if (prev_scl && !scl_line) begin
            fall_cnt <= fall_cnt + 1;
            tgt_low  <= tgt_next(fall_cnt + 1);
        end else if (!prev_scl && scl_line) begin
            if (fall_cnt >= 1 && fall_cnt <= 8) mon_addr <= {mon_addr[6:0], sda_line};
            else if (fall_cnt == 9) mon_aack <= sda_line;
            else if (fall_cnt >= 10 && fall_cnt <= 17) mon_data <= {mon_data[6:0], sda_line};
            else if (fall_cnt == 18) mon_dack <= sda_line;
        end
        if (prev_scl && scl_line && !prev_sda && sda_line) stop_fall <= fall_cnt;
    end

    // Cycle count since accept, stretch injector and response counter.
    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) since_acc <= 0;
        else since_acc <= since_acc + 1;
        stretch <= stretch_en && (since_acc >= 71) && (since_acc <= 107);
        if (rsp_valid) rsp_count <= rsp_count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [6:0] a, input logic r, input logic [7:0] d, input logic keep);
        @(negedge clk);
        cmd_addr  = a;
        cmd_rnw   = r;
        cmd_data  = d;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) cmd_valid = 1'b0;
    endtask

    // Counts clk edges from the last accept until rsp_valid is seen (0 = timeout).
    task automatic wait_rsp(output int n);
        n = 0;
        for (int i = 1; i <= 2000; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_scl", 32'(scl_oe), 32'd0);
        chk("rst_sda", 32'(sda_oe), 32'd0);
        chk("rst_rspv", 32'(rsp_valid), 32'd0);
        chk("rst_rspd", 32'(rsp_data), 32'h00);
        chk("rst_nack", 32'(rsp_nack), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // 1: write 5A / C3, target ACKs
        tgt_en = 1'b1;
        send(7'h5A, 1'b0, 8'hC3, 1'b0);
        chk("w_ready_low", 32'(cmd_ready), 32'd0);
        wait_rsp(lat);
        chk("w_lat", 32'(lat), 32'd320);
        chk("w_addr", 32'(mon_addr), 32'hB4);
        chk("w_aack", 32'(mon_aack), 32'd0);
        chk("w_data", 32'(mon_data), 32'hC3);
        chk("w_dack", 32'(mon_dack), 32'd0);
        chk("w_nack", 32'(rsp_nack), 32'd0);
        chk("w_rspd", 32'(rsp_data), 32'h00);
        chk("w_stop", 32'(stop_fall), 32'd19);
        chk("w_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("w_pulse", 32'(rsp_valid), 32'd0);
        repeat (10) @(posedge clk);

        // 2: read 5A, target returns 96
        tgt_rd = 8'h96;
        send(7'h5A, 1'b1, 8'h00, 1'b0);
        wait_rsp(lat);
        chk("r_lat", 32'(lat), 32'd320);
        chk("r_addr", 32'(mon_addr), 32'hB5);
        chk("r_bus", 32'(mon_data), 32'h96);
        chk("r_9th", 32'(mon_dack), 32'd1);
        chk("r_rspd", 32'(rsp_data), 32'h96);
        chk("r_nack", 32'(rsp_nack), 32'd0);
        @(posedge clk);
        #1;
        chk("r_hold", 32'(rsp_data), 32'h96);
        repeat (10) @(posedge clk);

        // 3: address NACK
        tgt_en = 1'b0;
        send(7'h11, 1'b0, 8'h55, 1'b0);
        wait_rsp(lat);
        chk("an_lat", 32'(lat), 32'd176);
        chk("an_addr", 32'(mon_addr), 32'h22);
        chk("an_aack", 32'(mon_aack), 32'd1);
        chk("an_stop", 32'(stop_fall), 32'd10);
        chk("an_nack", 32'(rsp_nack), 32'd1);
        chk("an_rspd", 32'(rsp_data), 32'h00);
        tgt_en = 1'b1;
        repeat (10) @(posedge clk);

        // 4: 37-cycle stretch in address bit a3 Q2
        send(7'h5A, 1'b0, 8'hC3, 1'b0);
        stretch_en = 1'b1;
        wait_rsp(lat);
        stretch_en = 1'b0;
        chk("st_lat", 32'(lat), 32'd357);
        chk("st_addr", 32'(mon_addr), 32'hB4);
        chk("st_data", 32'(mon_data), 32'hC3);
        chk("st_nack", 32'(rsp_nack), 32'd0);
        repeat (10) @(posedge clk);

        // 5: back-to-back, write then read with cmd_valid held
        tgt_rd = 8'h96;
        send(7'h5A, 1'b0, 8'hC3, 1'b1);
        @(negedge clk);
        cmd_rnw  = 1'b1;
        cmd_data = 8'h00;
        wait_rsp(lat);
        chk("bb1_lat", 32'(lat), 32'd320);
        chk("bb1_ready", 32'(cmd_ready), 32'd1);
        chk("bb1_data", 32'(mon_data), 32'hC3);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("bb2_accept", 32'(cmd_ready), 32'd0);
        chk("bb2_pulse", 32'(rsp_valid), 32'd0);
        wait_rsp(lat);
        chk("bb2_lat", 32'(lat), 32'd320);
        chk("bb2_addr", 32'(mon_addr), 32'hB5);
        chk("bb2_rspd", 32'(rsp_data), 32'h96);
        repeat (10) @(posedge clk);

        // 6: async reset in DATA bit 1 Q0 of a write of A5
        send(7'h5A, 1'b0, 8'hA5, 1'b0);
        repeat (176) @(posedge clk);
        #1;
        chk("rs_pre_scl", 32'(scl_oe), 32'd1);
        chk("rs_pre_sda", 32'(sda_oe), 32'd1);
        rst = 1'b1;
        #1;
        chk("rs_scl", 32'(scl_oe), 32'd0);
        chk("rs_sda", 32'(sda_oe), 32'd0);
        chk("rs_ready", 32'(cmd_ready), 32'd1);
        chk("rs_rspv", 32'(rsp_valid), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (400) @(posedge clk);
        #1;
        chk("rs_no_rsp", 32'(rsp_count), 32'd6);
        send(7'h5A, 1'b0, 8'h3C, 1'b0);
        wait_rsp(lat);
        chk("rs_lat", 32'(lat), 32'd320);
        chk("rs_addr", 32'(mon_addr), 32'hB4);
        chk("rs_data", 32'(mon_data), 32'h3C);
        chk("rs_nack", 32'(rsp_nack), 32'd0);
        @(posedge clk);
        #1;
        chk("rsp_total", 32'(rsp_count), 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
